alu_arbiter: RTL and testbench

- Shares one registered ALU between two requesters (instruction-side and auxiliary/microcode side) using round-robin arbitration.
- Sequences each operation: grant, issue, sample.
- Returns the result and flags to the granted requester, tagged with its requester id.
- Sits between the bexkat1 ALU instance and its clients. Owns the ALU operand and function inputs exclusively.

---
 rtl/alu_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one registered ALU (bexkat1 style, 1-cycle result latency) between
// two requesters: requester 0 (instruction side) and requester 1
// (auxiliary / microcode side). Ties are broken round-robin.
//
// Each operation runs through a fixed sequence:
//   IDLE   : arbitrate; a valid&ready handshake captures the operands.
//   ISSUE  : operand registers drive the ALU; the ALU registers its result.
//   SAMPLE : operands are held so the ALU's add/sub flags, which mix the live
//            inputs with the registered output, stay coherent; the result
//            and flags are captured at the end of this cycle.
//   RESP   : resp_valid_o is high until the consumer asserts resp_ready_i.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   req{0,1}_valid_i / _ready_o        request handshake (ready is combinational)
//   req{0,1}_in1_i, _in2_i, _func_i    operands and ALU function
//   alu_in1_o, alu_in2_o, alu_func_o   to the ALU, straight from operand regs
//   alu_out_i, alu_{c,z,n,v}_i         registered ALU result and its flags
//   resp_valid_o / resp_ready_i        response handshake
//   resp_id_o                          requester id the response belongs to
//   resp_out_o, resp_{c,z,n,v}_o       captured result and flags
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_in1_i,
  input  logic [WIDTH-1:0] req0_in2_i,
  input  logic [2:0]       req0_func_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_in1_i,
  input  logic [WIDTH-1:0] req1_in2_i,
  input  logic [2:0]       req1_func_i,

  output logic [WIDTH-1:0] alu_in1_o,
  output logic [WIDTH-1:0] alu_in2_o,
  output logic [2:0]       alu_func_o,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic             alu_c_i,
  input  logic             alu_z_i,
  input  logic             alu_n_i,
  input  logic             alu_v_i,

  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_id_o,
  output logic [WIDTH-1:0] resp_out_o,
  output logic             resp_c_o,
  output logic             resp_z_o,
  output logic             resp_n_o,
  output logic             resp_v_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;         // id of the last granted requester

  logic [WIDTH-1:0] op_in1_q, op_in1_d;
  logic [WIDTH-1:0] op_in2_q, op_in2_d;
  logic [2:0]       op_func_q, op_func_d;
  logic             op_id_q, op_id_d;

  logic [WIDTH-1:0] resp_out_q, resp_out_d;
  logic             resp_id_q, resp_id_d;
  logic             resp_c_q, resp_c_d;
  logic             resp_z_q, resp_z_d;
  logic             resp_n_q, resp_n_d;
  logic             resp_v_q, resp_v_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] grant_oh;
  logic       grant_id;
  logic       can_grant;
  logic       handshake;

  assign req_valid = {req1_valid_i, req0_valid_i};

  // A lone requester always wins; on a tie the one that did not go last wins.
  always_comb begin
    grant_id = 1'b0;
    unique case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~ptr_q;
      default: grant_id = 1'b0;
    endcase
  end

  assign grant_oh  = grant_id ? 2'b10 : 2'b01;
  // Readies are suppressed while reset is asserted even though state is IDLE.
  assign can_grant = (state_q == ST_IDLE) && !rst_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = can_grant && req_valid[gi] && grant_oh[gi];
    end
  endgenerate

  assign handshake    = |req_ready;
  assign req0_ready_o = req_ready[0];
  assign req1_ready_o = req_ready[1];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_in1_d   = op_in1_q;
    op_in2_d   = op_in2_q;
    op_func_d  = op_func_q;
    op_id_d    = op_id_q;
    resp_out_d = resp_out_q;
    resp_id_d  = resp_id_q;
    resp_c_d   = resp_c_q;
    resp_z_d   = resp_z_q;
    resp_n_d   = resp_n_q;
    resp_v_d   = resp_v_q;

    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d   = ST_ISSUE;
          ptr_d     = grant_id;
          op_id_d   = grant_id;
          op_in1_d  = grant_id ? req1_in1_i  : req0_in1_i;
          op_in2_d  = grant_id ? req1_in2_i  : req0_in2_i;
          op_func_d = grant_id ? req1_func_i : req0_func_i;
        end
      end

      ST_ISSUE: begin
        state_d = ST_SAMPLE;
      end

      ST_SAMPLE: begin
        // The ALU output registered at the end of ISSUE is visible now, and
        // the flags are valid because the operands are still being driven.
        state_d    = ST_RESP;
        resp_out_d = alu_out_i;
        resp_c_d   = alu_c_i;
        resp_z_d   = alu_z_i;
        resp_n_d   = alu_n_i;
        resp_v_d   = alu_v_i;
        resp_id_d  = op_id_q;
      end

      ST_RESP: begin
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b1;   // requester 0 wins the first tie
      op_in1_q   <= '0;
      op_in2_q   <= '0;
      op_func_q  <= '0;
      op_id_q    <= 1'b0;
      resp_out_q <= '0;
      resp_id_q  <= 1'b0;
      resp_c_q   <= 1'b0;
      resp_z_q   <= 1'b0;
      resp_n_q   <= 1'b0;
      resp_v_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_in1_q   <= op_in1_d;
      op_in2_q   <= op_in2_d;
      op_func_q  <= op_func_d;
      op_id_q    <= op_id_d;
      resp_out_q <= resp_out_d;
      resp_id_q  <= resp_id_d;
      resp_c_q   <= resp_c_d;
      resp_z_q   <= resp_z_d;
      resp_n_q   <= resp_n_d;
      resp_v_q   <= resp_v_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign alu_in1_o    = op_in1_q;
  assign alu_in2_o    = op_in2_q;
  assign alu_func_o   = op_func_q;

  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_id_o    = resp_id_q;
  assign resp_out_o   = resp_out_q;
  assign resp_c_o     = resp_c_q;
  assign resp_z_o     = resp_z_q;
  assign resp_n_o     = resp_n_q;
  assign resp_v_o     = resp_v_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. A small bexkat1-style ALU model (registered
// result, flags combining live inputs with the registered result) sits on the
// ALU side; expected results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam logic [2:0] ALU_AND     = 3'd0;
  localparam logic [2:0] ALU_OR      = 3'd1;
  localparam logic [2:0] ALU_ADD     = 3'd2;
  localparam logic [2:0] ALU_SUB     = 3'd3;
  localparam logic [2:0] ALU_LSHIFT  = 3'd4;
  localparam logic [2:0] ALU_RSHIFTA = 3'd5;
  localparam logic [2:0] ALU_RSHIFTL = 3'd6;
  localparam logic [2:0] ALU_XOR     = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_in1, req0_in2;
  logic [2:0]  req0_func;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_in1, req1_in2;
  logic [2:0]  req1_func;
  logic [31:0] alu_in1, alu_in2;
  logic [2:0]  alu_func;
  logic [31:0] alu_out;
  logic        alu_c, alu_z, alu_n, alu_v;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_out;
  logic        resp_c, resp_z, resp_n, resp_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_in1_i   (req0_in1),
    .req0_in2_i   (req0_in2),
    .req0_func_i  (req0_func),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_in1_i   (req1_in1),
    .req1_in2_i   (req1_in2),
    .req1_func_i  (req1_func),
    .alu_in1_o    (alu_in1),
    .alu_in2_o    (alu_in2),
    .alu_func_o   (alu_func),
    .alu_out_i    (alu_out),
    .alu_c_i      (alu_c),
    .alu_z_i      (alu_z),
    .alu_n_i      (alu_n),
    .alu_v_i      (alu_v),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_id_o    (resp_id),
    .resp_out_o   (resp_out),
    .resp_c_o     (resp_c),
    .resp_z_o     (resp_z),
    .resp_n_o     (resp_n),
    .resp_v_o     (resp_v)
  );

  // ---------------- ALU model ----------------
  function automatic logic [32:0] alu_calc(input logic [2:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    case (f)
      ALU_AND:     alu_calc = {1'b0, a & b};
      ALU_OR:      alu_calc = {1'b0, a | b};
      ALU_ADD:     alu_calc = {1'b0, a} + {1'b0, b};
      ALU_SUB:     alu_calc = {1'b0, a} - {1'b0, b};
      ALU_LSHIFT:  alu_calc = {1'b0, a << b[4:0]};
      ALU_RSHIFTA: alu_calc = {1'b0, $signed(a) >>> b[4:0]};
      ALU_RSHIFTL: alu_calc = {1'b0, a >> b[4:0]};
      default:     alu_calc = {1'b0, a ^ b};
    endcase
  endfunction

  logic [31:0] alu_res_q;
  logic        alu_c_q;

  always @(posedge clk) begin
    {alu_c_q, alu_res_q} <= alu_calc(alu_func, alu_in1, alu_in2);
  end

  assign alu_out = alu_res_q;
  assign alu_c   = alu_c_q;
  assign alu_z   = (alu_res_q == 32'd0);
  assign alu_n   = alu_res_q[31];
  assign alu_v   = (alu_func == ALU_ADD) ? ((alu_in1[31] == alu_in2[31]) && (alu_res_q[31] != alu_in1[31])) :
                   (alu_func == ALU_SUB) ? ((alu_in1[31] != alu_in2[31]) && (alu_res_q[31] != alu_in1[31])) :
                   1'b0;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic exp_id;

    rst        = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_in1   = '0; req0_in2 = '0; req0_func = ALU_AND;
    req1_in1   = '0; req1_in2 = '0; req1_func = ALU_AND;
    resp_ready = 1'b1;

    // Reset with both valids high
    tick();
    #1;
    chk("rst1_ready0", req0_ready, 0);
    chk("rst1_ready1", req1_ready, 0);
    chk("rst1_resp_valid", resp_valid, 0);
    chk("rst1_resp_out", resp_out, 0);
    chk("rst1_resp_id", resp_id, 0);
    chk("rst1_alu_in1", alu_in1, 0);
    tick();
    #1;
    chk("rst2_ready0", req0_ready, 0);
    chk("rst2_ready1", req1_ready, 0);
    chk("rst2_resp_flags", {resp_c, resp_z, resp_n, resp_v}, 0);

    // Single op: first tie goes to req0, ADD 5+7
    rst = 1'b0;
    req0_in1 = 32'd5;    req0_in2 = 32'd7;    req0_func = ALU_ADD;
    req1_in1 = 32'hF0;   req1_in2 = 32'h0F;   req1_func = ALU_OR;
    #1;
    chk("first_grant_ready0", req0_ready, 1);
    chk("first_grant_ready1", req1_ready, 0);
    tick();                                   // t+1
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("issue_alu_in1", alu_in1, 5);
    chk("issue_alu_in2", alu_in2, 7);
    chk("issue_alu_func", alu_func, ALU_ADD);
    chk("issue_ready0", req0_ready, 0);
    tick();                                   // t+2
    chk("sample_resp_valid", resp_valid, 0);
    chk("sample_alu_in1", alu_in1, 5);
    tick();                                   // t+3
    chk("add_resp_valid", resp_valid, 1);
    chk("add_resp_out", resp_out, 12);
    chk("add_resp_id", resp_id, 0);
    chk("add_resp_z", resp_z, 0);
    chk("add_resp_n", resp_n, 0);
    tick();                                   // t+4, back in IDLE
    chk("idle_resp_valid", resp_valid, 0);
    chk("idle_resp_out_hold", resp_out, 12);
    chk("idle_alu_in1_hold", alu_in1, 5);

    // Tie and fairness: 8 back-to-back ops, grants alternate starting with req1
    req0_in1 = 32'd3; req0_in2 = 32'd3; req0_func = ALU_SUB;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_id = (k % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      chk("tie_ready0", req0_ready, !exp_id);
      chk("tie_ready1", req1_ready, exp_id);
      tick();
      tick();
      tick();
      chk("tie_resp_valid", resp_valid, 1);
      chk("tie_resp_id", resp_id, exp_id);
      chk("tie_resp_out", resp_out, exp_id ? 32'hFF : 32'h0);
      chk("tie_resp_z", resp_z, !exp_id);
      tick();
    end

    // Backpressure: req0 ADD 100+23 held in RESP while req1 waits
    req1_valid = 1'b0;
    req0_in1 = 32'd100; req0_in2 = 32'd23; req0_func = ALU_ADD;
    resp_ready = 1'b0;
    #1;
    chk("bp_ready0", req0_ready, 1);
    tick();                                   // ISSUE
    req0_valid = 1'b0;
    req1_in1 = 32'h7FFF_FFFF; req1_in2 = 32'd1; req1_func = ALU_ADD;
    req1_valid = 1'b1;
    tick();                                   // SAMPLE
    tick();                                   // RESP
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_out", resp_out, 123);
      chk("bp_resp_id", resp_id, 0);
      chk("bp_ready1", req1_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_accept_valid", resp_valid, 1);
    chk("bp_accept_ready1", req1_ready, 0);
    tick();                                   // IDLE: req1 granted
    chk("bp_regrant_ready1", req1_ready, 1);
    chk("bp_regrant_resp_valid", resp_valid, 0);

    // Overflow passthrough: req1 0x7FFFFFFF + 1
    tick();                                   // ISSUE
    req1_valid = 1'b0;
    tick();                                   // SAMPLE
    tick();                                   // RESP
    chk("ovf_resp_valid", resp_valid, 1);
    chk("ovf_resp_out", resp_out, 32'h8000_0000);
    chk("ovf_resp_n", resp_n, 1);
    chk("ovf_resp_v", resp_v, 1);
    chk("ovf_resp_z", resp_z, 0);
    chk("ovf_resp_id", resp_id, 1);
    tick();                                   // IDLE

    // Idle with nothing requested stays idle
    tick();
    chk("quiet_ready0", req0_ready, 0);
    chk("quiet_resp_valid", resp_valid, 0);

    // Reset mid-operation: req0 ADD 1+1 moves pointer to 0, reset in SAMPLE
    req0_in1 = 32'd1; req0_in2 = 32'd1; req0_func = ALU_ADD;
    req0_valid = 1'b1;
    #1;
    chk("mid_ready0", req0_ready, 1);
    tick();                                   // ISSUE
    req0_valid = 1'b0;
    tick();                                   // SAMPLE
    rst = 1'b1;
    req0_in1 = 32'd10; req0_in2 = 32'd4; req0_func = ALU_SUB;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_rst_ready0", req0_ready, 0);
    chk("mid_rst_ready1", req1_ready, 0);
    tick();                                   // would have been RESP; now IDLE
    rst = 1'b0;
    #1;
    chk("mid_no_resp_valid", resp_valid, 0);
    chk("mid_resp_out_clr", resp_out, 0);
    chk("mid_alu_in1_clr", alu_in1, 0);
    chk("mid_ptr_ready0", req0_ready, 1);
    chk("mid_ptr_ready1", req1_ready, 0);
    tick();                                   // ISSUE
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();                                   // SAMPLE
    chk("post_rst_sample_valid", resp_valid, 0);
    tick();                                   // RESP
    chk("post_rst_resp_valid", resp_valid, 1);
    chk("post_rst_resp_out", resp_out, 6);
    chk("post_rst_resp_id", resp_id, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
